// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub4_slice.sv
// Combinational 4-bit ripple add/subtract slice: s=1 adds the one's complement of b (cin supplies the +1).
module addsub4_slice
  import nsa_pkg::*;
(
  input  logic             s,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic [NIB_W-1:0] sout
);

  logic [NIB_W:0]   c;
  logic [NIB_W-1:0] bx;

  always_comb begin
    bx   = b ^ {NIB_W{s}};
    c    = '0;
    sout = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sout[i]  = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    cout = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial DATA_W add/subtract: one 4-bit slice reused LSB-first with a registered carry chain.
// Optional accumulator operand source enabled by defining NSA_ACCUM_EN.
module nibble_serial_addsub
  import nsa_pkg::*;
#(
  parameter  int NUM_NIB = 4,
  localparam int DATA_W  = NIB_W * NUM_NIB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sub,
  input  logic              in_acc,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              busy
);

  localparam int IDX_W = clog2(NUM_NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] a_q, b_q, res_q, res_nxt, a_src;
  logic              sub_q, carry_q;
  logic              carry_f, ovf_f, zero_f;
  logic [NIB_W-1:0]  a_nib, b_nib, sout;
  logic              cout;
  logic              accept, run, last, handshake;

  assign accept    = (state == S_IDLE) && in_valid;
  assign run       = (state == S_RUN);
  assign last      = run && (idx == LAST_IDX);
  assign handshake = (state == S_DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_RUN;
      S_RUN:   if (last)      state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

`ifdef NSA_ACCUM_EN
  logic [DATA_W-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (rst)            acc_q <= '0;
    else if (handshake) acc_q <= res_q;
  end

  assign a_src = in_acc ? acc_q : in_a;
`else
  logic unused_acc;
  assign unused_acc = in_acc;
  assign a_src      = in_a;
`endif

  // Stage 0: operand capture at the accept edge only.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a_src;
      b_q   <= in_b;
      sub_q <= in_sub;
    end
  end

  // Nibble select and result merge for the current index.
  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    res_nxt = res_q;
    for (int i = 0; i < NUM_NIB; i++) begin
      if (idx == i[IDX_W-1:0]) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
        res_nxt[i*NIB_W +: NIB_W] = sout;
      end
    end
  end

  addsub4_slice u_slice (
    .s    (sub_q),
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .cout (cout),
    .sout (sout)
  );

  // Stage 1: one nibble per cycle; flags latched with the top nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      carry_f <= 1'b0;
      ovf_f   <= 1'b0;
      zero_f  <= 1'b0;
    end else if (accept) begin
      idx     <= '0;
      carry_q <= in_sub;
    end else if (run) begin
      res_q   <= res_nxt;
      carry_q <= cout;
      if (last) begin
        idx     <= '0;
        carry_f <= cout;
        ovf_f   <= (a_q[DATA_W-1] == (b_q[DATA_W-1] ^ sub_q)) &&
                   (sout[NIB_W-1] != a_q[DATA_W-1]);
        zero_f  <= (res_nxt == '0);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_result = res_q;
  assign out_carry  = carry_f;
  assign out_ovf    = ovf_f;
  assign out_zero   = zero_f;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub with an arithmetic reference model and per-cycle output checks.
module tb_nibble_serial_addsub;

  localparam int NUM_NIB = 4;
  localparam int DW      = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_sub, in_acc, out_ready;
  logic [DW-1:0] in_a, in_b, out_result;
  logic          in_ready, out_valid, out_carry, out_ovf, out_zero, busy;

  nibble_serial_addsub #(.NUM_NIB(NUM_NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sub     (in_sub),
    .in_acc     (in_acc),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] r;
    logic          c;
    logic          v;
    logic          z;
  } exp_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic [DW-1:0] r;
    logic          c;
    logic          v;
    logic          z;
  } vec_t;

  exp_t          exp_q[$];
  int            n_vec  = 0;
  int            n_fail = 0;
  logic [DW-1:0] acc_m  = '0;

  // Reference: full-width integer arithmetic, no nibble decomposition.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
    exp_t e;
    int   sa, sb, sr;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    sr  = sub ? (sa - sb) : (sa + sb);
    e.r = sub ? (a - b) : (a + b);
    e.c = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
    e.v = (sr > 32767) || (sr < -32768);
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare process: every cycle out_valid is high, outputs must match the model head.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_m = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        chk("model_result", out_result, exp_q[0].r);
        chk("model_carry",  out_carry,  exp_q[0].c);
        chk("model_ovf",    out_ovf,    exp_q[0].v);
        chk("model_zero",   out_zero,   exp_q[0].z);
        if (out_ready) begin
`ifdef NSA_ACCUM_EN
          acc_m = exp_q[0].r;
`endif
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sub, input logic acc);
    int            k;
    logic [DW-1:0] aa;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_acc   = acc;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    aa = a;
`ifdef NSA_ACCUM_EN
    if (acc) aa = acc_m;
`endif
    exp_q.push_back(model(aa, b, sub));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = DW'($urandom);
    in_b     = DW'($urandom);
    in_sub   = 1'($urandom);
    in_acc   = 1'($urandom);
  endtask

  // Counts cycles after the accept edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic sub, input logic acc, input logic [DW-1:0] r_exp);
    int n;
    start_op(a, b, sub, acc);
    wait_valid(n);
    chk({nm, "_latency"}, n, 32'd5);
    chk({nm, "_result"}, out_result, r_exp);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{a:16'h1234, b:16'h4321, sub:1'b0, r:16'h5555, c:1'b0, v:1'b0, z:1'b0};
    vecs[1] = '{a:16'h0005, b:16'h0005, sub:1'b1, r:16'h0000, c:1'b1, v:1'b0, z:1'b1};
    vecs[2] = '{a:16'h7FFF, b:16'h0001, sub:1'b0, r:16'h8000, c:1'b0, v:1'b1, z:1'b0};
    vecs[3] = '{a:16'h0000, b:16'h0001, sub:1'b1, r:16'hFFFF, c:1'b0, v:1'b0, z:1'b0};
    vecs[4] = '{a:16'h8000, b:16'h0001, sub:1'b1, r:16'h7FFF, c:1'b1, v:1'b1, z:1'b0};
    vecs[5] = '{a:16'hFFFF, b:16'h0001, sub:1'b0, r:16'h0000, c:1'b1, v:1'b0, z:1'b1};
    vecs[6] = '{a:16'h8000, b:16'h8000, sub:1'b0, r:16'h0000, c:1'b1, v:1'b1, z:1'b1};

    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_acc = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,   32'd1);
    chk("rst_out_valid", out_valid,  32'd0);
    chk("rst_busy",      busy,       32'd0);
    chk("rst_result",    out_result, 32'd0);
    chk("rst_flags",     {out_carry, out_ovf, out_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0);
      wait_valid(n);
      chk("latency",    n,          32'd5);
      chk("lit_result", out_result, vecs[i].r);
      chk("lit_carry",  out_carry,  vecs[i].c);
      chk("lit_ovf",    out_ovf,    vecs[i].v);
      chk("lit_zero",   out_zero,   vecs[i].z);
      @(posedge clk);
      #1;
      chk("post_hs_valid", out_valid, 32'd0);
    end

    // Backpressure: result held in DONE, new request waits for the cycle after the handshake.
    out_ready = 1'b0;
    start_op(16'h00FF, 16'h0101, 1'b0, 1'b0);
    wait_valid(n);
    in_a = 16'h0003; in_b = 16'h0004; in_sub = 1'b0; in_acc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid",    out_valid,  32'd1);
      chk("bp_in_ready", in_ready,   32'd0);
      chk("bp_result",   out_result, 32'h0200);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid",    out_valid, 32'd0);
    chk("bp_hs_in_ready", in_ready,  32'd1);
    chk("bp_hs_busy",     busy,      32'd0);
    exp_q.push_back(model(16'h0003, 16'h0004, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept_busy", busy, 32'd1);
    wait_valid(n);
    chk("bp2_latency", n,          32'd5);
    chk("bp2_result",  out_result, 32'h0007);
    @(posedge clk);
    #1;

    // Reset two cycles into RUN aborts the operation.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready",  in_ready,   32'd1);
    chk("abort_out_valid", out_valid,  32'd0);
    chk("abort_busy",      busy,       32'd0);
    chk("abort_result",    out_result, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 32'd0);
    end
    @(posedge clk);
    #1;
    run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002);

    // Without the accumulator build in_acc must be ignored.
    run_op("acc_ignored", 16'h0010, 16'h0005, 1'b0, 1'b1,
`ifdef NSA_ACCUM_EN
           16'h0007);
`else
           16'h0015);
`endif

`ifdef NSA_ACCUM_EN
    run_op("acc1", 16'h0010, 16'h0005, 1'b0, 1'b0, 16'h0015);
    run_op("acc2", 16'hBEEF, 16'h0003, 1'b1, 1'b1, 16'h0012);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("acc3", 16'hBEEF, 16'h0000, 1'b0, 1'b1, 16'h0000);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
